div_16_seq: RTL and testbench

Multi-cycle 16-bit restoring divider, the inverse operation to the team's 16-bit carry-lookahead adder path. It repeatedly shifts and subtracts, producing one quotient bit per clock. It sits beside the adder in the ALU and serves DIV/REM instructions through a start/done handshake. One shared 17-bit subtractor is reused every cycle instead of an unrolled array.

---
 rtl/div_16_pkg.sv | 24 ++
 rtl/div_16_seq_if.sv | 39 +++
 rtl/div_16_seq_sub_17.sv | 39 +++
 rtl/div_16_seq.sv | 142 ++++++++++++++
 tb/tb_div_16_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/div_16_pkg.sv
// div_16_pkg: shared types and constants for the 16-bit sequential divider.
// Holds the operand width, counter width, FSM encoding and div-by-zero quotient.
package div_16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF;

    // Two's-complement negate when n is set.
    function automatic logic [WIDTH-1:0] neg_if(
        input logic [WIDTH-1:0] v,
        input logic             n
    );
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/div_16_seq_if.sv
// div_16_seq_if: start/done request bundle between the ALU and the divider.
// master: start, dividend, divisor (is_signed with DIV_16_SIGNED_EN) out;
// busy, done, quotient, remainder, div_by_zero in. slave is the mirror.
interface div_16_seq_if;
    import div_16_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_16_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef DIV_16_SIGNED_EN
    modport master (
        output start, dividend, divisor, is_signed,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, is_signed,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif

endinterface

// File: rtl/div_16_seq_sub_17.sv
// sub_17: 17-bit subtractor d = a + ~b + 1 built from four 4-bit lookahead
// slices plus a 1-bit top stage. Ports: a, b in; d, borrow (a < b) out.
module sub_17 (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] d,
    output logic        borrow
);
    logic [16:0] w_g;
    logic [16:0] w_p;
    logic [17:0] w_c;

    assign w_g    = a & ~b;
    assign w_p    = a ^ ~b;
    assign w_c[0] = 1'b1;

    for (genvar s = 0; s < 4; s++) begin : g_cla
        localparam int B = 4 * s;
        assign w_c[B+1] = w_g[B]
                        | (w_p[B] & w_c[B]);
        assign w_c[B+2] = w_g[B+1]
                        | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2]
                        | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+4] = w_g[B+3]
                        | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end

    assign w_c[17] = w_g[16] | (w_p[16] & w_c[16]);
    assign d       = w_p ^ w_c[16:0];
    assign borrow  = ~w_c[17];

endmodule

// File: rtl/div_16_seq.sv
// div_16_seq: 16-bit restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async, active-low), bus (div_16_seq_if.slave).
// Optional signed mode: define DIV_16_SIGNED_EN to add bus.is_signed.
module div_16_seq
    import div_16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    div_16_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_zero;
    logic             r_dbz;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_last;
    logic             w_borrow;
    logic             w_b_zero;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_d;
    logic [WIDTH:0]   w_r_nx;
    logic [WIDTH-1:0] w_q_nx;

`ifdef DIV_16_SIGNED_EN
    assign w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    assign w_a_mag  = neg_if(bus.dividend, w_a_neg);
    assign w_b_mag  = neg_if(bus.divisor, w_b_neg);
    assign w_b_zero = (bus.divisor == '0);

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

    sub_17 u_sub (
        .a      (w_rs),
        .b      ({1'b0, r_div}),
        .d      (w_d),
        .borrow (w_borrow)
    );

    assign w_r_nx = w_borrow ? w_rs : w_d;
    assign w_q_nx = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero divisor still spends one cycle in BUSY so that its results
    // land on the same edge that raises done, like a normal division.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (r_zero || (r_cnt == CNT_W'(WIDTH - 1))) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_zero  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= w_b_zero ? bus.dividend : w_a_mag;
            r_div   <= w_b_mag;
            r_zero  <= w_b_zero;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_r   <= w_r_nx;
            r_q   <= w_q_nx;
            if (w_last) begin
                if (r_zero) begin
                    r_quot <= DIV0_QUOT;
                    r_rem  <= r_q;
                    r_dbz  <= 1'b1;
                end else begin
                    r_quot <= neg_if(w_q_nx, r_neg_q);
                    r_rem  <= neg_if(w_r_nx[WIDTH-1:0], r_neg_r);
                    r_dbz  <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_16_seq.sv
// tb_div_16_seq: scoreboard bench for div_16_seq.
// Expected results are queued at issue and checked on each done pulse.
module tb_div_16_seq;
    import div_16_pkg::*;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_16_seq_if bus ();

    div_16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t prev;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic        sgn);
        exp_t e;
        int   sa, sb2;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
        end else if (sgn) begin
            sa  = int'($signed(a));
            sb2 = int'($signed(b));
            e.q = 16'(sa / sb2);
            e.r = 16'(sa % sb2);
            e.dbz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest issued operation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            n_done++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient", 32'(bus.quotient), 32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic sgn);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIV_16_SIGNED_EN
        bus.is_signed = sgn;
`else
        if (sgn) $display("note: signed request in unsigned build");
`endif
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic sgn);
        int   n;
        int   lat;
        exp_t e;
        wait_idle();
        @(negedge clk);
        e   = model(a, b, sgn);
        lat = (b == 16'd0) ? 1 : 16;
        drive(a, b, sgn);
        sb.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if ((n == 1 || n == 8) && n <= lat) begin
                check("hold_q", 32'(bus.quotient), 32'(prev.q));
                check("hold_r", 32'(bus.remainder), 32'(prev.r));
            end
            if (bus.done) break;
        end
        check("latency", 32'(n - 1), 32'(lat));
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
        prev = e;
    endtask

    initial begin
        int d0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_16_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        prev  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'd100, 16'd7, 1'b0);
        do_op(16'hFFFF, 16'd1, 1'b0);
        repeat (5) @(negedge clk);
        check("stable_q", 32'(bus.quotient), 32'hFFFF);
        check("stable_r", 32'(bus.remainder), 32'h0);
        do_op(16'h0005, 16'hFFFF, 1'b0);
        do_op(16'd1234, 16'd0, 1'b0);
        do_op(16'd10, 16'd3, 1'b0);

        // Start pulsed mid-operation must be ignored.
        wait_idle();
        @(negedge clk);
        d0 = n_done;
        drive(16'd50, 16'd5, 1'b0);
        sb.push_back(model(16'd50, 16'd5, 1'b0));
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        drive(16'd9, 16'd3, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("one_done", 32'(n_done - d0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("ign_q", 32'(bus.quotient), 32'd10);

        // Reset during iteration 8 aborts without a done pulse.
        @(negedge clk);
        d0 = n_done;
        drive(16'd200, 16'd7, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        prev = '0;
        do_op(16'd20, 16'd6, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i == 3) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
            if (i == 1) b = 16'($urandom_range(1, 255));
            do_op(a, b, 1'b0);
        end

`ifdef DIV_16_SIGNED_EN
        do_op(16'hFFF9, 16'd2, 1'b1);
        do_op(16'd7, 16'hFFFE, 1'b1);
        do_op(16'h8000, 16'hFFFF, 1'b1);
        do_op(16'hFFF9, 16'd0, 1'b1);
        do_op(16'hFFF9, 16'd2, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
